icache_fill_ctrl: RTL and testbench

ICACHE_FILL_CTRL -- requirements
Module: icache_fill_ctrl

---
 rtl/icache_fill_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_icache_fill_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : icache_fill_ctrl
// Description : Fully associative single-word instruction cache with a
//               miss-fill FSM, FIFO replacement and miss/replacement counters.
// Revision    : 1.0 - initial release
// ============================================================================
module icache_fill_ctrl #(
    parameter int ENTRIES = 8,
    parameter int BITS    = 32
) (
    input  logic            clk,
    input  logic            rst_,
    input  logic [BITS-1:0] pc_addr,
    input  logic            fetch_req,
    input  logic            branch_or_jump,
    output logic [BITS-1:0] instr,
    output logic            instr_valid,
    output logic            stall,
    output logic            mem_rd,
    output logic [BITS-1:0] mem_addr,
    input  logic [BITS-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            cache_hit,
    output logic            cache_full,
    output logic [31:0]     miss_count,
    output logic [31:0]     repl_count
);

    localparam int IDXW = $clog2(ENTRIES);
    localparam int TAGW = BITS - 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ENTRIES-1:0] valid_q, valid_d;
    logic [IDXW-1:0]   fifo_ptr_q, fifo_ptr_d;
    logic              abort_q, abort_d;
    logic [31:0]       miss_count_q, miss_count_d;
    logic [31:0]       repl_count_q, repl_count_d;
    logic [BITS-1:0]   mem_addr_q, mem_addr_d;
    logic [BITS-1:0]   resp_data_q, resp_data_d;
    logic [TAGW-1:0]   tag_q  [ENTRIES];
    logic [BITS-1:0]   data_q [ENTRIES];

    logic              hit_any;
    logic [BITS-1:0]   hit_data;
    logic [IDXW-1:0]   victim_idx;
    logic              victim_found;
    logic              all_valid;
    logic              install;
    logic              unused_addr_bits;

    assign unused_addr_bits = ^pc_addr[1:0];
    assign all_valid        = &valid_q;

    // Tags are unique, so OR-ing matching lines yields the single hit word.
    always_comb begin
        hit_any  = 1'b0;
        hit_data = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (valid_q[i] && (tag_q[i] == pc_addr[BITS-1:2])) begin
                hit_any  = 1'b1;
                hit_data = hit_data | data_q[i];
            end
        end
    end

    // Lowest invalid line wins; with no free line fall back to the FIFO pointer.
    always_comb begin
        victim_idx   = fifo_ptr_q;
        victim_found = 1'b0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (!victim_found && !valid_q[i]) begin
                victim_idx   = IDXW'(i);
                victim_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        valid_d      = valid_q;
        fifo_ptr_d   = fifo_ptr_q;
        abort_d      = abort_q;
        miss_count_d = miss_count_q;
        repl_count_d = repl_count_q;
        mem_addr_d   = mem_addr_q;
        resp_data_d  = resp_data_q;
        install      = 1'b0;
        instr        = '0;
        instr_valid  = 1'b0;
        stall        = 1'b0;
        mem_rd       = 1'b0;

        case (state_q)
            IDLE: begin
                if (fetch_req && !branch_or_jump) begin
                    if (hit_any) begin
                        instr       = hit_data;
                        instr_valid = 1'b1;
                    end else begin
                        stall        = 1'b1;
                        mem_addr_d   = pc_addr;
                        miss_count_d = (miss_count_q == 32'hFFFF_FFFF) ? miss_count_q
                                                                      : miss_count_q + 32'd1;
                        state_d      = FILL;
                    end
                end
            end
            FILL: begin
                mem_rd = 1'b1;
                stall  = 1'b1;
                if (branch_or_jump) begin
                    abort_d = 1'b1;
                end
                if (mem_ack) begin
                    if (abort_q || branch_or_jump) begin
                        abort_d = 1'b0;
                        state_d = IDLE;
                    end else begin
                        install             = 1'b1;
                        valid_d[victim_idx] = 1'b1;
                        resp_data_d         = mem_rdata;
                        state_d             = RESP;
                        if (all_valid) begin
                            fifo_ptr_d   = fifo_ptr_q + 1'b1;
                            repl_count_d = (repl_count_q == 32'hFFFF_FFFF) ? repl_count_q
                                                                          : repl_count_q + 32'd1;
                        end
                    end
                end
            end
            RESP: begin
                if (!branch_or_jump) begin
                    instr       = resp_data_q;
                    instr_valid = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Hold every handshake output quiet while reset is asserted.
        if (!rst_) begin
            install     = 1'b0;
            instr       = '0;
            instr_valid = 1'b0;
            stall       = 1'b0;
            mem_rd      = 1'b0;
        end
    end

    assign mem_addr   = rst_ ? mem_addr_q : '0;
    assign cache_hit  = rst_ & hit_any;
    assign cache_full = rst_ & all_valid;
    assign miss_count = miss_count_q;
    assign repl_count = repl_count_q;

    always_ff @(posedge clk) begin
        if (!rst_) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            fifo_ptr_q   <= '0;
            abort_q      <= 1'b0;
            miss_count_q <= '0;
            repl_count_q <= '0;
            mem_addr_q   <= '0;
            resp_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            valid_q      <= valid_d;
            fifo_ptr_q   <= fifo_ptr_d;
            abort_q      <= abort_d;
            miss_count_q <= miss_count_d;
            repl_count_q <= repl_count_d;
            mem_addr_q   <= mem_addr_d;
            resp_data_q  <= resp_data_d;
        end
    end

    always_ff @(posedge clk) begin
        if (install) begin
            tag_q[victim_idx]  <= mem_addr_q[BITS-1:2];
            data_q[victim_idx] <= mem_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_icache_fill_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache_fill_ctrl
// Description : Directed vector table plus hand sequences for icache_fill_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_icache_fill_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_addr;
    logic        fetch_req;
    logic        branch_or_jump;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        mem_rd;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ack;
    logic        cache_hit;
    logic        cache_full;
    logic [31:0] miss_count;
    logic [31:0] repl_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    icache_fill_ctrl #(.ENTRIES(8), .BITS(32)) dut (
        .clk            (clk),
        .rst_           (rst_n),
        .pc_addr        (pc_addr),
        .fetch_req      (fetch_req),
        .branch_or_jump (branch_or_jump),
        .instr          (instr),
        .instr_valid    (instr_valid),
        .stall          (stall),
        .mem_rd         (mem_rd),
        .mem_addr       (mem_addr),
        .mem_rdata      (mem_rdata),
        .mem_ack        (mem_ack),
        .cache_hit      (cache_hit),
        .cache_full     (cache_full),
        .miss_count     (miss_count),
        .repl_count     (repl_count)
    );

    typedef struct {
        logic        rst_n, freq, boj, ack;
        logic [31:0] pc, rdata;
        logic        e_valid, e_stall, e_rd;
        logic [31:0] e_instr;
        logic        e_hit, e_full;
        logic [31:0] e_miss, e_repl;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic f, input logic b, input logic a,
                                input logic [31:0] pc, input logic [31:0] rd,
                                input logic ev, input logic es, input logic er,
                                input logic [31:0] ei, input logic eh, input logic ef,
                                input logic [31:0] em, input logic [31:0] erp);
        vec_t v;
        v.rst_n = r; v.freq = f; v.boj = b; v.ack = a; v.pc = pc; v.rdata = rd;
        v.e_valid = ev; v.e_stall = es; v.e_rd = er; v.e_instr = ei;
        v.e_hit = eh; v.e_full = ef; v.e_miss = em; v.e_repl = erp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; fetch_req = 1'b0; branch_or_jump = 1'b0; mem_ack = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    // Full miss transaction: miss cycle, lat FILL cycles (ack on the last), RESP.
    task automatic do_miss(input logic [31:0] addr, input logic [31:0] data, input int lat);
        pc_addr = addr; fetch_req = 1'b1; branch_or_jump = 1'b0; mem_ack = 1'b0;
        @(negedge clk);
        chk($sformatf("miss %h stall", addr), {31'b0, stall}, 32'd1);
        chk($sformatf("miss %h hit", addr), {31'b0, cache_hit}, 32'd0);
        cyc();
        for (int k = 0; k < lat; k++) begin
            mem_ack   = (k == lat - 1);
            mem_rdata = data;
            @(negedge clk);
            chk($sformatf("fill %h mem_rd", addr), {31'b0, mem_rd}, 32'd1);
            chk($sformatf("fill %h mem_addr", addr), mem_addr, addr);
            cyc();
        end
        mem_ack = 1'b0;
        @(negedge clk);
        chk($sformatf("resp %h valid", addr), {31'b0, instr_valid}, 32'd1);
        chk($sformatf("resp %h instr", addr), instr, data);
        chk($sformatf("resp %h stall", addr), {31'b0, stall}, 32'd0);
        cyc();
        fetch_req = 1'b0;
    endtask

    task automatic chk_hit(input logic [31:0] addr, input logic exp);
        pc_addr = addr; fetch_req = 1'b0;
        @(negedge clk);
        chk($sformatf("probe %h hit", addr), {31'b0, cache_hit}, {31'b0, exp});
        cyc();
    endtask

    task automatic chk_counts(input string tag, input logic [31:0] em, input logic [31:0] er);
        @(negedge clk);
        chk({tag, " miss_count"}, miss_count, em);
        chk({tag, " repl_count"}, repl_count, er);
        cyc();
    endtask

    initial begin
        vecs[0]  = mk(0,0,0,0, 32'h10, 0,           0,0,0, 32'h0,        0,0, 0,0);
        vecs[1]  = mk(0,1,0,0, 32'h10, 0,           0,0,0, 32'h0,        0,0, 0,0);
        vecs[2]  = mk(1,1,0,0, 32'h10, 0,           0,1,0, 32'h0,        0,0, 0,0);
        vecs[3]  = mk(1,1,0,0, 32'h10, 0,           0,1,1, 32'h0,        0,0, 1,0);
        vecs[4]  = mk(1,1,0,0, 32'h10, 0,           0,1,1, 32'h0,        0,0, 1,0);
        vecs[5]  = mk(1,1,0,1, 32'h10, 32'h2008000A,0,1,1, 32'h0,        0,0, 1,0);
        vecs[6]  = mk(1,1,0,0, 32'h10, 0,           1,0,0, 32'h2008000A, 1,0, 1,0);
        vecs[7]  = mk(1,1,0,0, 32'h10, 0,           1,0,0, 32'h2008000A, 1,0, 1,0);
        vecs[8]  = mk(1,0,0,0, 32'h10, 0,           0,0,0, 32'h0,        1,0, 1,0);
        vecs[9]  = mk(1,1,1,0, 32'h44, 0,           0,0,0, 32'h0,        0,0, 1,0);
        vecs[10] = mk(1,0,0,0, 32'h44, 0,           0,0,0, 32'h0,        0,0, 1,0);
        vecs[11] = mk(1,1,1,0, 32'h10, 0,           0,0,0, 32'h0,        1,0, 1,0);
        vecs[12] = mk(1,1,0,1, 32'h10, 32'hDEADBEEF,1,0,0, 32'h2008000A, 1,0, 1,0);

        rst_n = 1'b0; pc_addr = '0; fetch_req = 1'b0; branch_or_jump = 1'b0;
        mem_ack = 1'b0; mem_rdata = '0;

        for (int i = 0; i < NV; i++) begin
            rst_n = vecs[i].rst_n; fetch_req = vecs[i].freq; branch_or_jump = vecs[i].boj;
            mem_ack = vecs[i].ack; pc_addr = vecs[i].pc; mem_rdata = vecs[i].rdata;
            @(negedge clk);
            chk($sformatf("v%0d instr_valid", i), {31'b0, instr_valid}, {31'b0, vecs[i].e_valid});
            chk($sformatf("v%0d stall", i), {31'b0, stall}, {31'b0, vecs[i].e_stall});
            chk($sformatf("v%0d mem_rd", i), {31'b0, mem_rd}, {31'b0, vecs[i].e_rd});
            chk($sformatf("v%0d cache_hit", i), {31'b0, cache_hit}, {31'b0, vecs[i].e_hit});
            chk($sformatf("v%0d cache_full", i), {31'b0, cache_full}, {31'b0, vecs[i].e_full});
            chk($sformatf("v%0d miss_count", i), miss_count, vecs[i].e_miss);
            chk($sformatf("v%0d repl_count", i), repl_count, vecs[i].e_repl);
            if (vecs[i].e_valid || !vecs[i].rst_n)
                chk($sformatf("v%0d instr", i), instr, vecs[i].e_instr);
            if (!vecs[i].rst_n)
                chk($sformatf("v%0d mem_addr", i), mem_addr, 32'h0);
            cyc();
        end

        // Fill all eight lines, then exercise FIFO replacement.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            do_miss(32'(i * 4), 32'hA000_0000 | 32'(i * 4), 1 + (i % 3));
            @(negedge clk);
            chk($sformatf("full after %0d", i + 1), {31'b0, cache_full}, {31'b0, (i == 7)});
            cyc();
        end
        do_miss(32'h20, 32'hA000_0020, 2);
        chk_counts("ninth", 32'd9, 32'd1);
        chk_hit(32'h00, 1'b0);
        chk_hit(32'h04, 1'b1);
        do_miss(32'h00, 32'hB000_0000, 1);
        chk_counts("refetch0", 32'd10, 32'd2);
        chk_hit(32'h04, 1'b0);
        chk_hit(32'h08, 1'b1);
        chk_hit(32'h20, 1'b1);

        // Redirect during FILL, data arrives later and must be dropped.
        pc_addr = 32'h40; fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0; branch_or_jump = 1'b1;
        cyc();
        branch_or_jump = 1'b0;
        cyc();
        mem_ack = 1'b1; mem_rdata = 32'hC000_0040;
        @(negedge clk);
        chk("abort ack mem_rd", {31'b0, mem_rd}, 32'd1);
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("abort after mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("abort after valid", {31'b0, instr_valid}, 32'd0);
        chk("abort after stall", {31'b0, stall}, 32'd0);
        cyc();
        chk_hit(32'h40, 1'b0);
        chk_counts("abort", 32'd11, 32'd2);
        do_miss(32'h40, 32'hC000_0040, 2);
        chk_counts("remiss40", 32'd12, 32'd3);
        chk_hit(32'h08, 1'b0);

        // Redirect coincident with mem_ack counts as an abort.
        pc_addr = 32'h48; fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0; mem_ack = 1'b1; branch_or_jump = 1'b1; mem_rdata = 32'hC000_0048;
        @(negedge clk);
        chk("coinc mem_rd", {31'b0, mem_rd}, 32'd1);
        cyc();
        mem_ack = 1'b0; branch_or_jump = 1'b0;
        @(negedge clk);
        chk("coinc after valid", {31'b0, instr_valid}, 32'd0);
        chk("coinc after mem_rd", {31'b0, mem_rd}, 32'd0);
        cyc();
        chk_hit(32'h48, 1'b0);
        chk_counts("coinc", 32'd13, 32'd3);
        chk_hit(32'h0C, 1'b1);

        // Reset in the middle of a fill, followed by a stray ack.
        pc_addr = 32'h80; fetch_req = 1'b1;
        cyc();
        fetch_req = 1'b0;
        cyc();
        rst_n = 1'b0; pc_addr = 32'h0C;
        @(negedge clk);
        chk("rst stall", {31'b0, stall}, 32'd0);
        chk("rst mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("rst mem_addr", mem_addr, 32'h0);
        chk("rst cache_hit", {31'b0, cache_hit}, 32'd0);
        chk("rst cache_full", {31'b0, cache_full}, 32'd0);
        chk("rst instr", instr, 32'h0);
        cyc();
        rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hEEEE_0080;
        @(negedge clk);
        chk("post rst mem_rd", {31'b0, mem_rd}, 32'd0);
        chk("post rst stall", {31'b0, stall}, 32'd0);
        chk("post rst miss_count", miss_count, 32'd0);
        chk("post rst repl_count", repl_count, 32'd0);
        cyc();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post rst valid", {31'b0, instr_valid}, 32'd0);
        chk("post rst hit", {31'b0, cache_hit}, 32'd0);
        chk("post rst full", {31'b0, cache_full}, 32'd0);
        cyc();
        chk_hit(32'h80, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
